// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared definitions for the clock set controller: set FSM
//                state encoding, button codes and default timing values.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Set FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } set_state_t;

    // Default debounce and auto-repeat timing, in tick_set strobes
    localparam int unsigned C_DEBOUNCE_TICKS_DEF = 2;
    localparam int unsigned C_REPEAT_DELAY_DEF   = 5;

    // Button code is {hours, minutes}
    localparam logic [1:0] C_CODE_MIN  = 2'b01;
    localparam logic [1:0] C_CODE_HOUR = 2'b10;

    // Only a single pressed button selects a field; 00 and 11 mean "released"
    function automatic logic is_single(input logic [1:0] code);
        return (code == C_CODE_MIN) || (code == C_CODE_HOUR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchronizer plus tick-based debounce for the
//                2-bit button code. The accepted code is presented on the
//                same clk as the accepting tick_set strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = clock_pkg::C_DEBOUNCE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_set,
    input  logic [1:0] btn_raw,
    output logic [1:0] code
);

    localparam logic [2:0] c_ticks = 3'(DEBOUNCE_TICKS);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] r_code;
    logic [2:0] r_cnt;
    logic       w_stable;
    logic       w_accept;

    // Any clk-level change of the synchronized code restarts the count
    assign w_stable = (r_sync2 == r_prev);
    assign w_accept = tick_set && w_stable && (r_cnt == c_ticks - 3'd1);
    assign code     = w_accept ? r_prev : r_code;

    // Two-flop synchronizer for both buttons
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter (saturating) and accepted-code register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 2'b00;
            r_cnt  <= 3'd0;
            r_code <= 2'b00;
        end else begin
            r_prev <= r_sync2;
            if (!w_stable) begin
                r_cnt <= 3'd0;
            end else if (tick_set && (r_cnt != c_ticks)) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_accept) begin
                r_code <= r_prev;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_controller
//  Description : Time-set controller for a digital clock. Debounces the
//                hours/minutes buttons, issues first/auto-repeat increments
//                and gates the 1 Hz seconds advance while setting.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_set_controller #(
    parameter int unsigned DEBOUNCE_TICKS = clock_pkg::C_DEBOUNCE_TICKS_DEF,
    parameter int unsigned REPEAT_DELAY   = clock_pkg::C_REPEAT_DELAY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_1hz,
    input  logic tick_set,
    input  logic btn_hours,
    input  logic btn_minutes,
    output logic inc_sec,
    output logic inc_min,
    output logic inc_hour,
    output logic sec_clear,
    output logic set_mode
);
    import clock_pkg::*;

    localparam logic [3:0] c_repeat = 4'(REPEAT_DELAY);

    set_state_t r_state;
    set_state_t w_next;
    logic [3:0] r_rep;
    logic [3:0] w_rep;
    logic [1:0] w_code;
    logic       w_single;
    logic       w_inc_sec;
    logic       w_inc_min;
    logic       w_inc_hour;
    logic       w_sec_clear;
    logic       r_inc_sec;
    logic       r_inc_min;
    logic       r_inc_hour;
    logic       r_sec_clear;
    logic       r_set_mode;

    button_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_button_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_set (tick_set),
        .btn_raw  ({btn_hours, btn_minutes}),
        .code     (w_code)
    );

    assign w_single = is_single(w_code);

    // Next-state, repeat counter and increment decode; a release code always wins
    always_comb begin
        w_next      = r_state;
        w_rep       = r_rep;
        w_inc_sec   = 1'b0;
        w_inc_min   = 1'b0;
        w_inc_hour  = 1'b0;
        w_sec_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_single) begin
                    // Entering FIRST: the set increment pre-empts a coincident 1 Hz tick
                    w_next      = ST_FIRST;
                    w_rep       = c_repeat;
                    w_sec_clear = 1'b1;
                    w_inc_hour  = (w_code == C_CODE_HOUR);
                    w_inc_min   = (w_code == C_CODE_MIN);
                end else if (tick_1hz) begin
                    w_inc_sec = 1'b1;
                end
            end
            ST_FIRST: begin
                w_next = w_single ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!w_single) begin
                    w_next = ST_IDLE;
                end else if (r_rep == 4'd0) begin
                    w_next = ST_REPEAT;
                end else if (tick_set) begin
                    w_rep = r_rep - 4'd1;
                end
            end
            ST_REPEAT: begin
                if (!w_single) begin
                    w_next = ST_IDLE;
                end else if (tick_set) begin
                    w_inc_hour = (w_code == C_CODE_HOUR);
                    w_inc_min  = (w_code == C_CODE_MIN);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, repeat counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rep       <= 4'd0;
            r_inc_sec   <= 1'b0;
            r_inc_min   <= 1'b0;
            r_inc_hour  <= 1'b0;
            r_sec_clear <= 1'b0;
            r_set_mode  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rep       <= w_rep;
            r_inc_sec   <= w_inc_sec;
            r_inc_min   <= w_inc_min;
            r_inc_hour  <= w_inc_hour;
            r_sec_clear <= w_sec_clear;
            r_set_mode  <= (w_next != ST_IDLE);
        end
    end

    assign inc_sec   = r_inc_sec;
    assign inc_min   = r_inc_min;
    assign inc_hour  = r_inc_hour;
    assign sec_clear = r_sec_clear;
    assign set_mode  = r_set_mode;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_controller
//  Description : Directed bench for clock_set_controller: a table of button
//                hold scenarios plus hand-written corner-case sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_set_controller;

    logic clk;
    logic reset_n;
    logic tick_1hz;
    logic tick_set;
    logic btn_hours;
    logic btn_minutes;
    logic inc_sec;
    logic inc_min;
    logic inc_hour;
    logic sec_clear;
    logic set_mode;

    int n_cmp;
    int n_fail;
    int n_sec;
    int n_min;
    int n_hour;
    int n_clr;
    int n_onehot_err;

    clock_set_controller #(
        .DEBOUNCE_TICKS (2),
        .REPEAT_DELAY   (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_1hz    (tick_1hz),
        .tick_set    (tick_set),
        .btn_hours   (btn_hours),
        .btn_minutes (btn_minutes),
        .inc_sec     (inc_sec),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .sec_clear   (sec_clear),
        .set_mode    (set_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and one-hot watch, sampled on the falling edge
    always @(negedge clk) begin
        if (inc_sec)   n_sec  <= n_sec + 1;
        if (inc_min)   n_min  <= n_min + 1;
        if (inc_hour)  n_hour <= n_hour + 1;
        if (sec_clear) n_clr  <= n_clr + 1;
        if ((int'(inc_sec) + int'(inc_min) + int'(inc_hour)) > 1) n_onehot_err <= n_onehot_err + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One tick_set strobe, then enough quiet clocks for outputs to settle
    task automatic strobe();
        @(posedge clk); #1 tick_set = 1'b1;
        @(posedge clk); #1 tick_set = 1'b0;
        idle(8);
    endtask

    task automatic sec_pulse();
        @(posedge clk); #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
        idle(2);
    endtask

    task automatic release_all();
        btn_hours   = 1'b0;
        btn_minutes = 1'b0;
        idle(4);
        repeat (3) strobe();
    endtask

    typedef struct {
        logic hrs;
        logic mins;
        int   n_strobe;
        int   e_hour;
        int   e_min;
        int   e_clr;
        int   e_mode;
    } vec_t;

    vec_t vecs [8];
    int b_sec, b_min, b_hour, b_clr;

    initial begin
        n_cmp = 0; n_fail = 0;
        n_sec = 0; n_min = 0; n_hour = 0; n_clr = 0; n_onehot_err = 0;
        tick_1hz = 1'b0; tick_set = 1'b0; btn_hours = 1'b0; btn_minutes = 1'b0;
        reset_n = 1'b0;

        // Button pressed a few clks before strobe 1, held across n_strobe strobes.
        // Accept at strobe 2 (first increment), strobes 3..7 hold, repeat from 8 on.
        vecs[0] = '{1'b0, 1'b1, 12, 0, 6, 1, 1};
        vecs[1] = '{1'b1, 1'b0, 12, 6, 0, 1, 1};
        vecs[2] = '{1'b1, 1'b0,  1, 0, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b1,  2, 0, 1, 1, 1};
        vecs[4] = '{1'b1, 1'b0,  7, 1, 0, 1, 1};
        vecs[5] = '{1'b1, 1'b0,  8, 2, 0, 1, 1};
        vecs[6] = '{1'b1, 1'b1,  5, 0, 0, 0, 0};
        vecs[7] = '{1'b0, 1'b0,  3, 0, 0, 0, 0};

        idle(3);
        check("reset_outputs", int'({inc_sec, inc_min, inc_hour, sec_clear, set_mode}), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        idle(3);

        // Table of hold scenarios
        b_sec = n_sec;
        for (int i = 0; i < 8; i++) begin
            b_min = n_min; b_hour = n_hour; b_clr = n_clr;
            btn_hours   = vecs[i].hrs;
            btn_minutes = vecs[i].mins;
            idle(4);
            repeat (vecs[i].n_strobe) strobe();
            check($sformatf("vec%0d_inc_hour", i), n_hour - b_hour, vecs[i].e_hour);
            check($sformatf("vec%0d_inc_min", i),  n_min - b_min,   vecs[i].e_min);
            check($sformatf("vec%0d_sec_clear", i), n_clr - b_clr,  vecs[i].e_clr);
            check($sformatf("vec%0d_set_mode", i), int'(set_mode),  vecs[i].e_mode);
            release_all();
            check($sformatf("vec%0d_released", i), int'(set_mode), 0);
        end
        check("table_no_inc_sec", n_sec - b_sec, 0);

        // 1 Hz ticks in IDLE all pass through
        b_sec = n_sec;
        repeat (10) sec_pulse();
        check("idle_inc_sec", n_sec - b_sec, 10);

        // 1 Hz ticks during HOLD are dropped
        b_hour = n_hour;
        btn_hours = 1'b1;
        idle(4);
        repeat (2) strobe();
        b_sec = n_sec;
        repeat (10) sec_pulse();
        idle(5);
        check("hold_inc_sec", n_sec - b_sec, 0);
        check("hold_set_mode", int'(set_mode), 1);
        check("hold_first_hour", n_hour - b_hour, 1);
        release_all();

        // Hours held, then minutes added: treated as release
        b_hour = n_hour; b_min = n_min;
        btn_hours = 1'b1;
        idle(4);
        repeat (4) strobe();
        btn_minutes = 1'b1;
        idle(4);
        repeat (2) strobe();
        check("both_set_mode", int'(set_mode), 0);
        repeat (10) strobe();
        check("both_inc_hour", n_hour - b_hour, 1);
        check("both_inc_min", n_min - b_min, 0);
        release_all();

        // tick_1hz coincident with the accepting strobe
        btn_hours = 1'b1;
        idle(4);
        strobe();
        @(posedge clk); #1 tick_set = 1'b1; tick_1hz = 1'b1;
        @(posedge clk); #1 tick_set = 1'b0; tick_1hz = 1'b0;
        check("coinc_inc_hour", int'(inc_hour), 1);
        check("coinc_inc_sec", int'(inc_sec), 0);
        check("coinc_sec_clear", int'(sec_clear), 1);
        @(posedge clk); #1;
        check("coinc_no_late_sec", int'({inc_sec, inc_hour}), 0);
        idle(8);
        release_all();

        // Reset asserted during REPEAT, button kept held through it
        btn_minutes = 1'b1;
        idle(4);
        repeat (9) strobe();
        check("pre_reset_set_mode", int'(set_mode), 1);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({inc_sec, inc_min, inc_hour, sec_clear, set_mode}), 0);
        idle(2);
        reset_n = 1'b1;
        b_min = n_min;
        idle(4);
        strobe();
        check("post_reset_no_pulse", n_min - b_min, 0);
        check("post_reset_set_mode", int'(set_mode), 0);
        strobe();
        check("post_reset_debounced", n_min - b_min, 1);
        release_all();

        check("onehot_violations", n_onehot_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 2, meaning the number of consecutive tick_set strobes a button level must be stable before it is accepted (range 1-7).
REQ-002 SHALL have parameter REPEAT_DELAY, default 5, meaning the number of tick_set strobes a button is held after its first increment before auto-repeat starts (range 1-15).
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tick_1hz  input  1  one-clk strobe, once per second.
REQ-006 tick_set  input  1  one-clk strobe, approx. 5 Hz; the set/debounce time base.
REQ-007 btn_hours  input  1  asynchronous, active-high hours-set button.
REQ-008 btn_minutes  input  1  asynchronous, active-high minutes-set button.
REQ-009 inc_sec  output  1  one-clk pulse: advance the seconds counter.
REQ-010 inc_min  output  1  one-clk pulse: advance the minutes counter, no carry into hours.
REQ-011 inc_hour  output  1  one-clk pulse: advance the hours counter.
REQ-012 sec_clear  output  1  one-clk pulse: clear the seconds counter.
REQ-013 set_mode  output  1  level; high while a set button is accepted and held.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Debounce: a synchronized button code {hours,minutes} SHALL be accepted only after it is unchanged at DEBOUNCE_TICKS consecutive tick_set strobes; any change restarts the count at 0.
REQ-016 FSM states: IDLE, FIRST, HOLD, REPEAT.
REQ-017 IDLE: on an accepted code 01 or 10, go to FIRST; codes 00 and 11 stay in IDLE.
REQ-018 FIRST (one clk): emit one inc_hour (code 10) or inc_min (code 01) together with sec_clear; load the repeat counter with REPEAT_DELAY; go to HOLD.
REQ-019 HOLD: decrement the repeat counter on each tick_set; when it reaches 0, go to REPEAT.
REQ-020 REPEAT: emit one inc_hour/inc_min for each tick_set strobe, in the clk following that strobe.
REQ-021 In FIRST, HOLD or REPEAT, an accepted code of 00 or 11 SHALL return the FSM to IDLE with no further increment. Two buttons pressed together count as a release.
REQ-022 set_mode SHALL be high in FIRST, HOLD and REPEAT, and low in IDLE.
REQ-023 inc_sec SHALL pulse on the clk after tick_1hz only when set_mode is low; tick_1hz while set_mode is high is dropped, not queued.
REQ-024 Outputs SHALL be registered. At most one of inc_sec, inc_min, inc_hour SHALL be high in any clk.
REQ-025 If tick_1hz and tick_set coincide on the IDLE-to-FIRST transition, the set increment wins and inc_sec is suppressed.
REQ-026 The debounce counter SHALL saturate, never wrap. The repeat counter SHALL be 4 bits and SHALL not underflow.

Reset
REQ-027 reset_n low SHALL asynchronously force: FSM to IDLE; synchronizers, debounce counter, repeat counter and accepted code to 0; all outputs to 0.
REQ-028 Reset asserted mid-set SHALL abort without any trailing increment pulse. After release the FSM requires a fresh debounce.

Structure
REQ-029 FSM state encoding and the default DEBOUNCE_TICKS/REPEAT_DELAY values SHALL live in the shared package clock_pkg.
REQ-030 The synchronizer plus debounce for one button-code SHALL be a sub-module named button_debounce, instantiated once on the 2-bit code.

Verification
REQ-031 Hold btn_minutes for 12 tick_set strobes (defaults) -> inc_min count 1 (FIRST) + 5 (REPEAT) = 6. sec_clear exactly once. set_mode high throughout. No inc_sec.
REQ-032 Glitch btn_hours high for 1 tick_set strobe only -> no inc_hour; set_mode stays 0.
REQ-033 btn_hours held, then btn_minutes added -> after 2 strobes the FSM is in IDLE; no inc_min ever; inc_hour stops.
REQ-034 10 tick_1hz strobes in IDLE -> exactly 10 inc_sec. The same 10 strobes during HOLD -> 0 inc_sec.
REQ-035 Assert reset_n low during REPEAT -> all outputs 0 within the same clk. After release, no pulse until a new debounce completes.
REQ-036 tick_1hz coincident with the FIRST transition -> inc_hour=1, inc_sec=0 in that clk. Onehot check holds across the whole run.
